cla_pipe_adder: RTL and testbench

Parametrised, pipelined carry-lookahead adder/subtractor. Operands are split into GROUP-bit slices. Each pipeline stage resolves one slice with full flat lookahead logic, and the slice carry-out is registered into the next stage. It sits between operand registers and the ALU result mux wherever a wide add no longer meets timing as a single combinational lookahead block, and it adds a subtract mode, overflow detection and a valid/ready handshake.

---
 rtl/cla_pipe_adder.sv | 124 ++++++++++++
 tb/tb_cla_pipe_adder.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cla_pipe_adder.sv
// Pipelined carry-lookahead adder/subtractor: one GROUP-bit lookahead slice per stage,
// slice carries registered between stages, valid/ready handshake with global stall.
module cla_pipe_adder #(
    parameter int WIDTH = 16,
    parameter int GROUP = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] ina,
    input  logic [WIDTH-1:0] inb,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int GSAFE  = (GROUP < 1) ? 1 : GROUP;
    localparam int STAGES = (WIDTH / GSAFE < 1) ? 1 : WIDTH / GSAFE;

    generate
        if (GROUP < 1 || WIDTH < GROUP || (WIDTH % GSAFE) != 0) begin : g_bad_cfg
            $error("cla_pipe_adder: WIDTH must be a positive multiple of GROUP");
        end
    endgenerate

    // Flat two-level lookahead: every carry is a single OR of AND terms, no ripple chain.
    function automatic logic [GSAFE:0] lookahead(input logic [GSAFE-1:0] p,
                                                 input logic [GSAFE-1:0] g,
                                                 input logic             c0);
        logic [GSAFE:0] c;
        logic           term;
        c    = '0;
        c[0] = c0;
        for (int i = 0; i < GSAFE; i++) begin
            term = c0;
            for (int k = 0; k <= i; k++) term = term & p[k];
            c[i+1] = term;
            for (int j = 0; j <= i; j++) begin
                term = g[j];
                for (int k = j + 1; k <= i; k++) term = term & p[k];
                c[i+1] = c[i+1] | term;
            end
        end
        return c;
    endfunction

    logic             v_q   [STAGES];
    logic             c_q   [STAGES];
    logic [WIDTH-1:0] a_q   [STAGES];
    logic [WIDTH-1:0] b_q   [STAGES];
    logic [WIDTH-1:0] s_q   [STAGES];
    logic [WIDTH-1:0] nxt_sum [STAGES];
    logic             c_out [STAGES];
    logic             msb_carry;
    logic             stall;

    assign stall    = out_valid & ~out_ready;
    assign in_ready = ~stall;

    generate
        for (genvar s = 0; s < STAGES; s++) begin : g_stage
            logic [GSAFE-1:0] p;
            logic [GSAFE-1:0] g;
            logic [GSAFE:0]   c;
            logic [WIDTH-1:0] merged;

            assign p = a_q[s][s*GSAFE +: GSAFE] ^ b_q[s][s*GSAFE +: GSAFE];
            assign g = a_q[s][s*GSAFE +: GSAFE] & b_q[s][s*GSAFE +: GSAFE];
            assign c = lookahead(p, g, c_q[s]);

            always_comb begin
                merged                    = s_q[s];
                merged[s*GSAFE +: GSAFE]  = p ^ c[GSAFE-1:0];
            end

            assign nxt_sum[s] = merged;
            assign c_out[s]   = c[GSAFE];

            if (s == STAGES - 1) begin : g_last
                assign msb_carry = c[GSAFE-1];
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < STAGES; s++) begin
                v_q[s] <= 1'b0;
                c_q[s] <= 1'b0;
                a_q[s] <= '0;
                b_q[s] <= '0;
                s_q[s] <= '0;
            end
            out_valid <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
        end else if (!stall) begin
            // Operand B is pre-inverted on entry so every stage only ever adds.
            v_q[0] <= in_valid;
            c_q[0] <= sub | cin;
            a_q[0] <= ina;
            b_q[0] <= inb ^ {WIDTH{sub}};
            s_q[0] <= '0;
            for (int s = 1; s < STAGES; s++) begin
                v_q[s] <= v_q[s-1];
                c_q[s] <= c_out[s-1];
                a_q[s] <= a_q[s-1];
                b_q[s] <= b_q[s-1];
                s_q[s] <= nxt_sum[s-1];
            end
            out_valid <= v_q[STAGES-1];
            sum       <= nxt_sum[STAGES-1];
            cout      <= c_out[STAGES-1];
            ovf       <= c_out[STAGES-1] ^ msb_carry;
        end
    end

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Self-checking bench: directed cases on 16/4, random scoreboarded traffic on 16/4, 32/8 and 8/8.
module tb_cla_pipe_adder;

    logic clk = 1'b0;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    logic        a_iv, a_ir, a_cin, a_sub, a_ov, a_or, a_cout, a_ovf;
    logic [15:0] a_ina, a_inb, a_sum;
    logic        b_iv, b_ir, b_cin, b_sub, b_ov, b_or, b_cout, b_ovf;
    logic [31:0] b_ina, b_inb, b_sum;
    logic        c_iv, c_ir, c_cin, c_sub, c_ov, c_or, c_cout, c_ovf;
    logic [7:0]  c_ina, c_inb, c_sum;

    cla_pipe_adder #(.WIDTH(16), .GROUP(4)) dut_a (
        .clk(clk), .rst(rst), .in_valid(a_iv), .in_ready(a_ir), .ina(a_ina), .inb(a_inb),
        .cin(a_cin), .sub(a_sub), .out_valid(a_ov), .out_ready(a_or), .sum(a_sum),
        .cout(a_cout), .ovf(a_ovf));
    cla_pipe_adder #(.WIDTH(32), .GROUP(8)) dut_b (
        .clk(clk), .rst(rst), .in_valid(b_iv), .in_ready(b_ir), .ina(b_ina), .inb(b_inb),
        .cin(b_cin), .sub(b_sub), .out_valid(b_ov), .out_ready(b_or), .sum(b_sum),
        .cout(b_cout), .ovf(b_ovf));
    cla_pipe_adder #(.WIDTH(8), .GROUP(8)) dut_c (
        .clk(clk), .rst(rst), .in_valid(c_iv), .in_ready(c_ir), .ina(c_ina), .inb(c_inb),
        .cin(c_cin), .sub(c_sub), .out_valid(c_ov), .out_ready(c_or), .sum(c_sum),
        .cout(c_cout), .ovf(c_ovf));

    // Reference: plain integer arithmetic, overflow from operand/result signs.
    function automatic logic [65:0] model(input int w, input logic [63:0] a, input logic [63:0] b,
                                          input logic ci, input logic sb);
        logic [63:0] mask, aa, bb, full, s;
        logic        co, ov;
        mask = (64'd1 << w) - 64'd1;
        aa   = a & mask;
        bb   = (sb ? ~b : b) & mask;
        full = aa + bb + (sb ? 64'd1 : {63'd0, ci});
        s    = full & mask;
        co   = full[w];
        ov   = (aa[w-1] == bb[w-1]) && (s[w-1] != aa[w-1]);
        return {co, ov, s};
    endfunction

    logic [65:0] qa[$], qb[$], qc[$];
    int acc_a = 0, acc_b = 0, acc_c = 0;

    always @(negedge clk) begin : mon_a
        logic [65:0] e;
        if (rst) qa.delete();
        else begin
            if (a_ov === 1'b1 && a_or) begin
                n_tests++;
                if (qa.size() == 0) begin
                    n_fail++; $display("FAIL mon_a unexpected result: got %h, required none", a_sum);
                end else begin
                    e = qa.pop_front();
                    if ({a_cout, a_ovf, 48'd0, a_sum} !== e) begin
                        n_fail++; $display("FAIL mon_a result: got %h, required %h", {a_cout, a_ovf, 48'd0, a_sum}, e);
                    end
                end
            end
            if (a_iv && a_ir === 1'b1) begin
                qa.push_back(model(16, 64'(a_ina), 64'(a_inb), a_cin, a_sub)); acc_a++;
            end
        end
    end

    always @(negedge clk) begin : mon_b
        logic [65:0] e;
        if (rst) qb.delete();
        else begin
            if (b_ov === 1'b1 && b_or) begin
                n_tests++;
                if (qb.size() == 0) begin
                    n_fail++; $display("FAIL mon_b unexpected result: got %h, required none", b_sum);
                end else begin
                    e = qb.pop_front();
                    if ({b_cout, b_ovf, 32'd0, b_sum} !== e) begin
                        n_fail++; $display("FAIL mon_b result: got %h, required %h", {b_cout, b_ovf, 32'd0, b_sum}, e);
                    end
                end
            end
            if (b_iv && b_ir === 1'b1) begin
                qb.push_back(model(32, 64'(b_ina), 64'(b_inb), b_cin, b_sub)); acc_b++;
            end
        end
    end

    always @(negedge clk) begin : mon_c
        logic [65:0] e;
        if (rst) qc.delete();
        else begin
            if (c_ov === 1'b1 && c_or) begin
                n_tests++;
                if (qc.size() == 0) begin
                    n_fail++; $display("FAIL mon_c unexpected result: got %h, required none", c_sum);
                end else begin
                    e = qc.pop_front();
                    if ({c_cout, c_ovf, 56'd0, c_sum} !== e) begin
                        n_fail++; $display("FAIL mon_c result: got %h, required %h", {c_cout, c_ovf, 56'd0, c_sum}, e);
                    end
                end
            end
            if (c_iv && c_ir === 1'b1) begin
                qc.push_back(model(8, 64'(c_ina), 64'(c_inb), c_cin, c_sub)); acc_c++;
            end
        end
    end

    task automatic set_a(input logic [15:0] a, input logic [15:0] b, input logic ci, input logic sb);
        a_ina = a; a_inb = b; a_cin = ci; a_sub = sb; a_iv = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_tests += 7;
        if (a_ov !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b, required 0", a_ov); end
        if (a_sum !== 16'h0) begin n_fail++; $display("FAIL reset_sum: got %h, required 0000", a_sum); end
        if (a_cout !== 1'b0) begin n_fail++; $display("FAIL reset_cout: got %b, required 0", a_cout); end
        if (a_ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b, required 0", a_ovf); end
        if (a_ir !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b, required 1", a_ir); end
        if (b_ov !== 1'b0) begin n_fail++; $display("FAIL reset_b_out_valid: got %b, required 0", b_ov); end
        if (c_ov !== 1'b0) begin n_fail++; $display("FAIL reset_c_out_valid: got %b, required 0", c_ov); end
        rst = 1'b0;
        @(posedge clk);
        #1;
        n_tests++;
        if (a_ir !== 1'b1) begin n_fail++; $display("FAIL post_reset_in_ready: got %b, required 1", a_ir); end
    endtask

    // Accepts one beat at the next edge and waits for its result; lat counts edges after acceptance.
    task automatic run_beat(input logic [15:0] a, input logic [15:0] b, input logic ci, input logic sb,
                            output logic [15:0] s, output logic co, output logic ov, output int lat);
        a_or = 1'b1;
        set_a(a, b, ci, sb);
        @(posedge clk);
        #1;
        a_iv = 1'b0;
        lat = 0;
        while (a_ov !== 1'b1 && lat < 12) begin
            @(posedge clk);
            #1;
            lat++;
        end
        s = a_sum; co = a_cout; ov = a_ovf;
    endtask

    task automatic test_add_sub();
        logic [15:0] ta [6] = '{16'hFFFF, 16'h7FFF, 16'h1234, 16'h0005, 16'h8000, 16'h0005};
        logic [15:0] tb [6] = '{16'h0001, 16'h0001, 16'h4321, 16'h0007, 16'h0001, 16'h0007};
        logic        tc [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        logic        tsb[6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        logic [15:0] es [6] = '{16'h0000, 16'h8000, 16'h5556, 16'hFFFE, 16'h7FFF, 16'hFFFE};
        logic        eco[6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        logic        eov[6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        logic [15:0] s;
        logic        co, ov;
        int          lat;
        for (int i = 0; i < 6; i++) begin
            run_beat(ta[i], tb[i], tc[i], tsb[i], s, co, ov, lat);
            n_tests += 4;
            if (lat !== 4) begin n_fail++; $display("FAIL addsub_latency[%0d]: got %0d, required 4", i, lat); end
            if (s !== es[i]) begin n_fail++; $display("FAIL addsub_sum[%0d]: got %h, required %h", i, s, es[i]); end
            if (co !== eco[i]) begin n_fail++; $display("FAIL addsub_cout[%0d]: got %b, required %b", i, co, eco[i]); end
            if (ov !== eov[i]) begin n_fail++; $display("FAIL addsub_ovf[%0d]: got %b, required %b", i, ov, eov[i]); end
        end
        @(posedge clk);
        #1;
    endtask

    // Eight beats back to back; optional 3-cycle out_ready drop starting at negedge stall_at.
    task automatic test_stream(input int stall_at);
        logic [65:0] exp [8];
        logic [15:0] xa[8], xb[8];
        logic        xc[8], xs[8];
        logic [15:0] held = '0;
        logic        prev_stall = 1'b0;
        int idx = 0, got = 0, t_acc0 = -1, t_out0 = -1, nstall = 0;
        for (int i = 0; i < 8; i++) begin
            xa[i] = 16'($urandom); xb[i] = 16'($urandom);
            xc[i] = 1'($urandom);  xs[i] = 1'($urandom);
            exp[i] = model(16, 64'(xa[i]), 64'(xb[i]), xc[i], xs[i]);
        end
        a_or = 1'b1;
        set_a(xa[0], xb[0], xc[0], xs[0]);
        for (int t = 0; t < 40 && got < 8; t++) begin
            @(negedge clk);
            if (a_ov === 1'b1 && a_or) begin
                n_tests++;
                if ({a_cout, a_ovf, 48'd0, a_sum} !== exp[got]) begin
                    n_fail++; $display("FAIL stream_data[%0d]: got %h, required %h", got, {a_cout, a_ovf, 48'd0, a_sum}, exp[got]);
                end
                if (t_out0 < 0) t_out0 = t;
                else if (stall_at < 0) begin
                    n_tests++;
                    if (t != t_out0 + got) begin
                        n_fail++; $display("FAIL stream_gap[%0d]: got cycle %0d, required %0d", got, t, t_out0 + got);
                    end
                end
                got++;
            end
            if (a_ov === 1'b1 && !a_or) begin
                nstall++;
                n_tests++;
                if (a_ir !== 1'b0) begin n_fail++; $display("FAIL stall_in_ready: got %b, required 0", a_ir); end
                if (prev_stall) begin
                    n_tests++;
                    if (a_sum !== held) begin n_fail++; $display("FAIL stall_hold: got %h, required %h", a_sum, held); end
                end
                prev_stall = 1'b1;
            end else prev_stall = 1'b0;
            held = a_sum;
            if (a_iv && a_ir === 1'b1) begin
                if (idx == 0) t_acc0 = t;
                idx++;
            end
            @(posedge clk);
            #1;
            a_or = !(stall_at >= 0 && t + 1 >= stall_at && t + 1 < stall_at + 3);
            if (idx < 8) set_a(xa[idx], xb[idx], xc[idx], xs[idx]);
            else a_iv = 1'b0;
        end
        a_iv = 1'b0;
        a_or = 1'b1;
        n_tests += 2;
        if (got != 8) begin n_fail++; $display("FAIL stream_count: got %0d, required 8", got); end
        if (stall_at < 0) begin
            // Acceptance edge follows negedge t_acc0; result seen at the negedge after edge +4.
            if (t_out0 - t_acc0 != 5) begin
                n_fail++; $display("FAIL stream_latency: got %0d, required 5", t_out0 - t_acc0);
            end
        end else if (nstall != 3) begin
            n_fail++; $display("FAIL stall_cycles: got %0d, required 3", nstall);
        end
        repeat (6) @(posedge clk);
        #1;
    endtask

    task automatic test_reset_flush();
        int nvalid = 0, lat = -1;
        logic [15:0] s = '0;
        logic co = 1'b0, ov = 1'b0;
        a_or = 1'b1;
        set_a(16'hAAAA, 16'h1111, 1'b0, 1'b0); @(posedge clk); #1;
        set_a(16'h5555, 16'h2222, 1'b1, 1'b0); @(posedge clk); #1;
        set_a(16'h3333, 16'h4444, 1'b0, 1'b1); @(posedge clk); #1;
        a_iv = 1'b0;
        rst  = 1'b1;
        @(posedge clk);
        #1;
        n_tests += 2;
        if (a_ov !== 1'b0) begin n_fail++; $display("FAIL flush_out_valid: got %b, required 0", a_ov); end
        if (a_sum !== 16'h0) begin n_fail++; $display("FAIL flush_sum: got %h, required 0000", a_sum); end
        rst = 1'b0;
        set_a(16'h0F0F, 16'h00F1, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        a_iv = 1'b0;
        for (int t = 1; t <= 12; t++) begin
            @(posedge clk);
            #1;
            if (a_ov === 1'b1) begin
                nvalid++;
                if (lat < 0) begin lat = t; s = a_sum; co = a_cout; ov = a_ovf; end
            end
        end
        n_tests += 3;
        if (nvalid != 1) begin n_fail++; $display("FAIL flush_result_count: got %0d, required 1", nvalid); end
        if (lat != 4) begin n_fail++; $display("FAIL flush_latency: got %0d, required 4", lat); end
        if ({co, ov, s} !== {1'b0, 1'b0, 16'h1000}) begin
            n_fail++; $display("FAIL flush_result: got %h, required %h", {co, ov, s}, {1'b0, 1'b0, 16'h1000});
        end
    endtask

    task automatic test_random();
        int cyc = 0;
        acc_a = 0; acc_b = 0; acc_c = 0;
        while ((acc_a < 10000 || acc_b < 10000 || acc_c < 10000) && cyc < 60000) begin
            @(posedge clk);
            #1;
            cyc++;
            a_iv = ($urandom_range(0, 9) < 8); a_ina = 16'($urandom); a_inb = 16'($urandom);
            a_cin = 1'($urandom); a_sub = 1'($urandom); a_or = ($urandom_range(0, 9) < 7);
            b_iv = ($urandom_range(0, 9) < 8); b_ina = $urandom; b_inb = $urandom;
            b_cin = 1'($urandom); b_sub = 1'($urandom); b_or = ($urandom_range(0, 9) < 7);
            c_iv = ($urandom_range(0, 9) < 8); c_ina = 8'($urandom); c_inb = 8'($urandom);
            c_cin = 1'($urandom); c_sub = 1'($urandom); c_or = ($urandom_range(0, 9) < 7);
        end
        a_iv = 1'b0; b_iv = 1'b0; c_iv = 1'b0;
        a_or = 1'b1; b_or = 1'b1; c_or = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        n_tests += 4;
        if (acc_a < 10000 || acc_b < 10000 || acc_c < 10000) begin
            n_fail++; $display("FAIL random_budget: accepted %0d/%0d/%0d, required 10000 each", acc_a, acc_b, acc_c);
        end
        if (qa.size() != 0) begin n_fail++; $display("FAIL drain_a: got %0d pending, required 0", qa.size()); end
        if (qb.size() != 0) begin n_fail++; $display("FAIL drain_b: got %0d pending, required 0", qb.size()); end
        if (qc.size() != 0) begin n_fail++; $display("FAIL drain_c: got %0d pending, required 0", qc.size()); end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL timeout: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end

    initial begin
        rst  = 1'b1;
        a_iv = 1'b0; a_ina = '0; a_inb = '0; a_cin = 1'b0; a_sub = 1'b0; a_or = 1'b1;
        b_iv = 1'b0; b_ina = '0; b_inb = '0; b_cin = 1'b0; b_sub = 1'b0; b_or = 1'b1;
        c_iv = 1'b0; c_ina = '0; c_inb = '0; c_cin = 1'b0; c_sub = 1'b0; c_or = 1'b1;
        test_reset();
        test_add_sub();
        test_stream(-1);
        test_stream(7);
        test_reset_flush();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
